// File: rtl/aes_guard_pkg.sv
// Shared types and constants for the redundant-AES result guard.
package aes_guard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DECIDE  = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  localparam logic MODE_STRICT   = 1'b0;
  localparam logic MODE_MAJORITY = 1'b1;

  function automatic int fault_cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/aes_lane_vote.sv
// Combinational strict/majority vote over captured lane results.
module aes_lane_vote
  import aes_guard_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int LANES  = 3
) (
  input  logic [LANES-1:0][DATA_W-1:0] cap_data,
  input  logic [LANES-1:0]             cap_mask,
  input  logic                         mode,
  output logic                         pass,
  output logic [DATA_W-1:0]            value,
  output logic                         corrected
);

  localparam int CW  = $clog2(LANES + 1);
  localparam int MAJ = LANES / 2 + 1;

  // agree[i]: captured lanes holding the same value as lane i (itself included)
  logic [LANES-1:0][CW-1:0] agree;

  always_comb begin
    agree = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if (cap_mask[i] && cap_mask[j] && (cap_data[i] == cap_data[j]))
          agree[i] = agree[i] + CW'(1);
      end
    end
  end

  always_comb begin
    pass      = 1'b0;
    value     = '0;
    corrected = 1'b0;
    if (mode == MODE_MAJORITY) begin
      // A majority value is unique, so scan order only picks among equal copies.
      for (int i = LANES - 1; i >= 0; i--) begin
        if (agree[i] >= CW'(MAJ)) begin
          pass      = 1'b1;
          value     = cap_data[i];
          corrected = (agree[i] != CW'(LANES));
        end
      end
    end else if (agree[0] == CW'(LANES)) begin
      pass  = 1'b1;
      value = cap_data[0];
    end
  end

endmodule

// File: rtl/aes_redundancy_voter.sv
// Collects redundant AES lane results, votes, counts faults and locks out.
module aes_redundancy_voter
  import aes_guard_pkg::*;
#(
  parameter int DATA_W      = 128,
  parameter int LANES       = 3,
  parameter int TIMEOUT     = 64,
  parameter int FAULT_LIMIT = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   mode,
  input  logic [LANES-1:0]                       lane_valid,
  input  logic [LANES*DATA_W-1:0]                lane_data,
  output logic                                   busy,
  output logic                                   out_valid,
  output logic [DATA_W-1:0]                      out_data,
  output logic                                   fault,
  output logic                                   corrected,
  output logic                                   timeout_err,
  output logic [fault_cnt_w(FAULT_LIMIT)-1:0]    fault_cnt,
  output logic                                   locked
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = fault_cnt_w(FAULT_LIMIT);

  logic [LANES-1:0][DATA_W-1:0] lane_arr;
  assign lane_arr = lane_data;

  state_e                       state_q, state_d;
  logic                         mode_q, mode_d;
  logic [LANES-1:0]             mask_q, mask_d;
  logic [LANES-1:0][DATA_W-1:0] cap_q, cap_d;
  logic [TW-1:0]                timer_q, timer_d;
  logic                         tmo_q, tmo_d;
  logic                         out_valid_q, out_valid_d;
  logic [DATA_W-1:0]            out_data_q, out_data_d;
  logic                         fault_q, fault_d;
  logic                         corrected_q, corrected_d;
  logic                         timeout_err_q, timeout_err_d;
  logic [CW-1:0]                fault_cnt_q, fault_cnt_d;
  logic                         locked_q, locked_d;

  logic                         vote_pass, vote_corrected;
  logic [DATA_W-1:0]            vote_value;

  aes_lane_vote #(.DATA_W(DATA_W), .LANES(LANES)) u_vote (
    .cap_data  (cap_q),
    .cap_mask  (mask_q),
    .mode      (mode_q),
    .pass      (vote_pass),
    .value     (vote_value),
    .corrected (vote_corrected)
  );

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    mask_d        = mask_q;
    cap_d         = cap_q;
    timer_d       = timer_q;
    tmo_d         = tmo_q;
    out_valid_d   = 1'b0;
    out_data_d    = out_data_q;
    fault_d       = fault_q;
    corrected_d   = corrected_q;
    timeout_err_d = timeout_err_q;
    fault_cnt_d   = fault_cnt_q;
    locked_d      = locked_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COLLECT;
          mode_d  = mode;
          mask_d  = '0;
          timer_d = '0;
          tmo_d   = 1'b0;
        end
      end
      ST_COLLECT: begin
        for (int i = 0; i < LANES; i++) begin
          if (lane_valid[i] && !mask_q[i]) begin
            mask_d[i] = 1'b1;
            cap_d[i]  = lane_arr[i];
          end
        end
        timer_d = timer_q + TW'(1);
        // A lane arriving in the final timer cycle still completes the set.
        if (&mask_d) begin
          state_d = ST_DECIDE;
        end else if (timer_d == TW'(TIMEOUT)) begin
          state_d = ST_DECIDE;
          tmo_d   = 1'b1;
        end
      end
      ST_DECIDE: begin
        out_valid_d   = 1'b1;
        timeout_err_d = tmo_q;
        if (vote_pass && !tmo_q) begin
          out_data_d  = vote_value;
          fault_d     = 1'b0;
          corrected_d = vote_corrected;
          state_d     = ST_IDLE;
        end else begin
          out_data_d  = '0;
          fault_d     = 1'b1;
          corrected_d = 1'b0;
          if (fault_cnt_q != CW'(FAULT_LIMIT))
            fault_cnt_d = fault_cnt_q + CW'(1);
          if (fault_cnt_d == CW'(FAULT_LIMIT)) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mode_q        <= 1'b0;
      mask_q        <= '0;
      cap_q         <= '0;
      timer_q       <= '0;
      tmo_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      fault_q       <= 1'b0;
      corrected_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      fault_cnt_q   <= '0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      mask_q        <= mask_d;
      cap_q         <= cap_d;
      timer_q       <= timer_d;
      tmo_q         <= tmo_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      fault_q       <= fault_d;
      corrected_q   <= corrected_d;
      timeout_err_q <= timeout_err_d;
      fault_cnt_q   <= fault_cnt_d;
      locked_q      <= locked_d;
    end
  end

  assign busy        = (state_q == ST_COLLECT) || (state_q == ST_DECIDE);
  assign out_valid   = out_valid_q;
  assign out_data    = (state_q == ST_LOCKED) ? '0 : out_data_q;
  assign fault       = fault_q;
  assign corrected   = corrected_q;
  assign timeout_err = timeout_err_q;
  assign fault_cnt   = fault_cnt_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_aes_redundancy_voter.sv
// Directed scoreboard bench for aes_redundancy_voter (LANES=3, TIMEOUT=8, FAULT_LIMIT=2).
module tb_aes_redundancy_voter;

  localparam int DW = 128;
  localparam int NL = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 mode = 1'b0;
  logic [NL-1:0]        lane_valid = '0;
  logic [NL*DW-1:0]     lane_data = '0;
  logic                 busy, out_valid, fault, corrected, timeout_err, locked;
  logic [DW-1:0]        out_data;
  logic [1:0]           fault_cnt;

  aes_redundancy_voter #(.DATA_W(DW), .LANES(NL), .TIMEOUT(8), .FAULT_LIMIT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .lane_valid  (lane_valid),
    .lane_data   (lane_data),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .fault       (fault),
    .corrected   (corrected),
    .timeout_err (timeout_err),
    .fault_cnt   (fault_cnt),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          flt;
    logic          corr;
    logic          tmo;
    logic [1:0]    cnt;
    logic          lck;
    int            at;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  localparam logic [DW-1:0] C  = 128'h3925841D02DC09FBDC118597196A0B32;
  localparam logic [DW-1:0] CF = 128'h3925841D02DC09FBDC118597196A0B33;
  localparam logic [DW-1:0] D  = 128'h00112233445566778899AABBCCDDEEFF;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sbq.size() == 0) begin
        chk("spurious_out_valid", DW'(out_valid), '0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_cycle", DW'(cyc), DW'(e.at));
        chk("out_data", out_data, e.data);
        chk("fault", DW'(fault), DW'(e.flt));
        chk("corrected", DW'(corrected), DW'(e.corr));
        chk("timeout_err", DW'(timeout_err), DW'(e.tmo));
        chk("fault_cnt", DW'(fault_cnt), DW'(e.cnt));
        chk("locked", DW'(locked), DW'(e.lck));
      end
    end
  end

  // Issue start; lat is the spec cycle number of out_valid counted from the start edge.
  task automatic issue(input logic m, input logic [DW-1:0] d, input logic f, input logic cr,
                       input logic t, input logic [1:0] n, input logic l, input int lat);
    exp_t e;
    e.data = d; e.flt = f; e.corr = cr; e.tmo = t; e.cnt = n; e.lck = l;
    e.at = cyc + lat;
    sbq.push_back(e);
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive(input logic [NL-1:0] v, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    lane_valid = v;
    lane_data  = {d2, d1, d0};
    @(posedge clk); #1;
    lane_valid = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sbq.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk("scoreboard_drain", DW'(sbq.size()), '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_fault_cnt", DW'(fault_cnt), '0);
    chk("rst_locked", DW'(locked), '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // strict pass
    issue(1'b0, C, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3);
    drive(3'b111, C, C, C);
    drain();

    // majority corrects lane 2
    issue(1'b1, C, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3);
    drive(3'b111, C, C, CF);
    drain();

    // duplicate lane-0 strobe and a start pulse inside COLLECT are both ignored
    issue(1'b0, C, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4);
    drive(3'b001, C, '0, '0);
    start = 1'b1;
    drive(3'b111, D, C, C);
    start = 1'b0;
    drain();

    // strict mismatch
    issue(1'b0, '0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 3);
    drive(3'b111, C, C, CF);
    drain();

    // timeout with lane 1 silent: second fault locks
    issue(1'b0, '0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 10);
    drive(3'b101, C, '0, C);
    drain();
    chk("locked_after_timeout", DW'(locked), 1);

    do_reset();
    chk("post_rst_locked", DW'(locked), '0);
    chk("post_rst_fault_cnt", DW'(fault_cnt), '0);

    // two mismatching operations -> lockout
    issue(1'b0, '0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 3);
    drive(3'b111, C, D, C);
    drain();
    issue(1'b1, '0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 3);
    drive(3'b111, C, D, CF);
    drain();

    // start ignored while locked
    start = 1'b1;
    drive(3'b111, C, C, C);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("locked_busy", DW'(busy), '0);
      @(posedge clk); #1;
    end
    chk("locked_hold", DW'(locked), 1);
    chk("locked_out_data", out_data, '0);

    do_reset();
    chk("unlock_locked", DW'(locked), '0);
    chk("unlock_fault_cnt", DW'(fault_cnt), '0);
    issue(1'b0, C, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3);
    drive(3'b111, C, C, C);
    drain();

    // reset mid-operation after lane 0 captured
    start = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    drive(3'b001, D, '0, '0);
    rst = 1'b1;
    #1;
    chk("midrst_busy", DW'(busy), '0);
    chk("midrst_out_data", out_data, '0);
    chk("midrst_fault", DW'(fault), '0);
    chk("midrst_corrected", DW'(corrected), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // fresh operation must wait for lane 0 again
    issue(1'b0, C, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4);
    drive(3'b110, '0, C, C);
    chk("needs_lane0", DW'(busy), 1);
    drive(3'b001, C, '0, '0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
